mc_datapath: RTL and testbench

- Multicycle successor to the single-cycle 32-bit datapath.
- Executes one instruction over 3–5 states through a single unified memory port with a req/ready handshake, so memory may insert wait states.
- Register file depth and data width are parametrised.
- Exposes the latched instruction to the external combinational controller and consumes that controller's decoded signals; the sequencing FSM is internal.

---
 rtl/mc_datapath.sv | 251 +++++++++++++++++++++++++
 tb/tb_mc_datapath.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_datapath.sv
// mc_datapath: multicycle 32-bit datapath with one shared memory port.
//
// Each instruction runs through FETCH -> DECODE -> EXEC [-> MEM] [-> WB].
// Instruction fetch and data accesses share one req/ready port, so memory
// may stall either phase by holding mem_ready low. The latched instruction
// goes out on `instr` to an external combinational controller, and the
// decoded control inputs come back from it. The state sequencing is local.
//
// Parameters:
//   n        data/address width (>= 32); instruction fields sit in [31:0]
//   ra       register address width; 2**ra registers, jal links to the top one
//   PC_RESET PC value loaded on reset
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   instr                 instruction register, to the controller
//   memtoreg .. jal       decoded control from the controller
//   alucontrol            ALU operation select
//   mem_req/we/addr/wdata memory request side
//   mem_rdata/mem_ready   memory response side
//   pc                    current program counter
//   instr_done            one-cycle pulse in the last state of an instruction
//
// Optional build macro MC_DATAPATH_PERF_EN adds the free-running
// cycle_count and instret_count outputs.
module mc_datapath #(
  parameter int          n        = 32,
  parameter int          ra       = 7,
  parameter logic [n-1:0] PC_RESET = '0
) (
  input  logic          clk,
  input  logic          reset,
  output logic [31:0]   instr,
  input  logic          memtoreg,
  input  logic          memwrite,
  input  logic          branch,
  input  logic          alusrc,
  input  logic          regdst,
  input  logic          regwrite,
  input  logic          jump,
  input  logic          jr,
  input  logic          jal,
  input  logic [3:0]    alucontrol,
  output logic          mem_req,
  output logic          mem_we,
  output logic [n-1:0]  mem_addr,
  output logic [n-1:0]  mem_wdata,
  input  logic [n-1:0]  mem_rdata,
  input  logic          mem_ready,
  output logic [n-1:0]  pc,
  output logic          instr_done
`ifdef MC_DATAPATH_PERF_EN
  ,
  output logic [n-1:0]  cycle_count,
  output logic [n-1:0]  instret_count
`endif
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam int NREG = 2 ** ra;

  logic [2:0]   state_q, state_d;
  logic [n-1:0] pc_q, pc_d;
  logic [n-1:0] pc4_q, pc4_d;
  logic [31:0]  ir_q, ir_d;
  logic [n-1:0] a_q, a_d;
  logic [n-1:0] b_q, b_d;
  logic [n-1:0] aluout_q, aluout_d;
  logic [n-1:0] mdr_q, mdr_d;
  logic [n-1:0] rf_q [NREG];

  logic          rf_we;
  logic [ra-1:0] rf_waddr;
  logic [n-1:0]  rf_wdata;

  logic          req_c, we_c, done_c;
  logic [n-1:0]  addr_c;

  function automatic logic [n-1:0] alu_f(input logic [n-1:0] x,
                                         input logic [n-1:0] y,
                                         input logic [3:0]   ctl);
    logic signed [n-1:0] xs, ys;
    xs = x;
    ys = y;
    case (ctl)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return x + y;
      4'b0110: return x - y;
      4'b0111: return {{(n-1){1'b0}}, (xs < ys)};
      4'b1100: return ~(x | y);
      default: return '0;
    endcase
  endfunction

  logic [ra-1:0] rs_a, rt_a, rd_a;
  logic [n-1:0]  rs_val, rt_val, signimm, srcb, alu_res;
  logic [n-1:0]  jtarget, btarget;
  logic          zero;

  assign rs_a = ra'(ir_q[25:19]);
  assign rt_a = ra'(ir_q[18:12]);
  assign rd_a = ra'(ir_q[11:5]);

  // Register 0 is forced to read zero regardless of array contents.
  assign rs_val = (rs_a == '0) ? '0 : rf_q[rs_a];
  assign rt_val = (rt_a == '0) ? '0 : rf_q[rt_a];

  assign signimm = {{(n-12){ir_q[11]}}, ir_q[11:0]};
  assign srcb    = alusrc ? signimm : b_q;
  assign alu_res = alu_f(a_q, srcb, alucontrol);
  assign zero    = (alu_res == '0);
  assign jtarget = {pc4_q[n-1:28], ir_q[25:0], 2'b00};
  assign btarget = pc4_q + (signimm << 2);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc4_d    = pc4_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    aluout_d = aluout_q;
    mdr_d    = mdr_q;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    req_c    = 1'b0;
    we_c     = 1'b0;
    addr_c   = pc_q;
    done_c   = 1'b0;
    case (state_q)
      S_FETCH: begin
        req_c  = 1'b1;
        addr_c = pc_q;
        if (mem_ready) begin
          ir_d    = mem_rdata[31:0];
          pc4_d   = pc_q + n'(4);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rs_val;
        b_d     = rt_val;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        aluout_d = alu_res;
        // jr outranks jump/jal so that jr+jal links but returns to A.
        if (jr)                 pc_d = a_q;
        else if (jump || jal)   pc_d = jtarget;
        else if (branch && zero) pc_d = btarget;
        else                    pc_d = pc4_q;
        if (memtoreg || memwrite)  state_d = S_MEM;
        else if (regwrite || jal)  state_d = S_WB;
        else begin
          state_d = S_FETCH;
          done_c  = 1'b1;
        end
      end
      S_MEM: begin
        req_c  = 1'b1;
        we_c   = memwrite;
        addr_c = aluout_q;
        if (mem_ready) begin
          if (memwrite) begin
            done_c  = 1'b1;
            state_d = S_FETCH;
          end else begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we = 1'b1;
        if (jal) begin
          rf_waddr = '1;
          rf_wdata = pc4_q;
        end else begin
          rf_waddr = regdst ? rd_a : rt_a;
          rf_wdata = memtoreg ? mdr_q : aluout_q;
        end
        done_c  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= PC_RESET;
      pc4_q    <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc4_q    <= pc4_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
      mdr_q    <= mdr_d;
      if (rf_we && (rf_waddr != '0)) rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // Reset parks the FSM in FETCH; the request is masked so nothing reaches
  // memory until reset is released.
  assign mem_req    = req_c & ~reset;
  assign mem_we     = we_c & ~reset;
  assign instr_done = done_c & ~reset;
  assign mem_addr   = addr_c;
  assign mem_wdata  = b_q;
  assign instr      = ir_q;
  assign pc         = pc_q;

`ifdef MC_DATAPATH_PERF_EN
  logic [n-1:0] cyc_q, cyc_d;
  logic [n-1:0] ret_q, ret_d;

  assign cyc_d = cyc_q + n'(1);
  assign ret_d = done_c ? (ret_q + n'(1)) : ret_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
    end
  end

  assign cycle_count   = cyc_q;
  assign instret_count = ret_q;
`endif

endmodule

// File: tb/tb_mc_datapath.sv
module tb_mc_datapath;

  localparam logic [31:0] SENT = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr;
  logic        memtoreg, memwrite, branch, alusrc, regdst, regwrite;
  logic        jump, jr, jal;
  logic [3:0]  alucontrol;
  logic        mem_req, mem_we, mem_ready, instr_done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

  int checks = 0;
  int failures = 0;

  // Memory model: fetches (address == pc) are zero-wait, data accesses
  // take dwait wait cycles before ready.
  logic [31:0] mem [0:1023];
  int          wcnt = 0;
  int          dwait = 0;
  logic        ld_en = 1'b0, ld_clr = 1'b0;
  logic [31:0] ld_addr = '0, ld_data = '0;

  always #5 clk = ~clk;

  mc_datapath #(.n(32), .ra(7), .PC_RESET(32'h100)) dut (
    .clk(clk), .reset(reset), .instr(instr),
    .memtoreg(memtoreg), .memwrite(memwrite), .branch(branch),
    .alusrc(alusrc), .regdst(regdst), .regwrite(regwrite),
    .jump(jump), .jr(jr), .jal(jal), .alucontrol(alucontrol),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc(pc), .instr_done(instr_done)
  );

  always_comb begin
    mem_ready = mem_req && ((mem_addr == pc) || (wcnt >= dwait));
    mem_rdata = mem[mem_addr[11:2]];
  end

  always @(posedge clk) begin
    if (ld_clr) for (int i = 0; i < 1024; i++) mem[i] <= SENT;
    else if (ld_en) mem[ld_addr[11:2]] <= ld_data;
    else if (mem_req && mem_we && mem_ready) mem[mem_addr[11:2]] <= mem_wdata;
    if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  // Controller: op 0 R-type (alu in [3:0]), 8 addi, 35 lw, 43 sw, 4 beq,
  // 2 j, 3 jal, 1 jr.
  always_comb begin
    memtoreg = 0; memwrite = 0; branch = 0; alusrc = 0; regdst = 0;
    regwrite = 0; jump = 0; jr = 0; jal = 0; alucontrol = 4'b0010;
    case (instr[31:26])
      6'd0:  begin regwrite = 1; regdst = 1; alucontrol = instr[3:0]; end
      6'd8:  begin regwrite = 1; alusrc = 1; end
      6'd35: begin memtoreg = 1; regwrite = 1; alusrc = 1; end
      6'd43: begin memwrite = 1; alusrc = 1; end
      6'd4:  begin branch = 1; alucontrol = 4'b0110; end
      6'd2:  jump = 1;
      6'd3:  jal = 1;
      6'd1:  jr = 1;
      default: ;
    endcase
  end

  function automatic logic [31:0] ei(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 7'(rs), 7'(rt), 12'(imm)};
  endfunction
  function automatic logic [31:0] er(input int alu, input int rs, input int rt, input int rd);
    return {6'd0, 7'(rs), 7'(rt), 7'(rd), 1'b0, 4'(alu)};
  endfunction
  function automatic logic [31:0] ej(input int op, input int target);
    return {6'(op), 26'(target >> 2)};
  endfunction

  task automatic begin_test(input int waits);
    @(negedge clk);
    reset = 1; dwait = waits; ld_clr = 1;
    @(negedge clk);
    ld_clr = 0;
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    ld_en = 1; ld_addr = 32'(a); ld_data = d;
    @(negedge clk);
    ld_en = 0;
  endtask

  task automatic release_rst();
    reset = 0;
    #1;
  endtask

  // Runs one instruction from its first FETCH cycle; returns the cycle count
  // up to and including the instr_done cycle, and checks that the request
  // stays frozen across every wait cycle.
  task automatic run_instr(input string nm, output int lat);
    logic        hold, got, h_we;
    logic [31:0] h_addr, h_wdata;
    hold = 0; got = 0; lat = 0; h_we = 0; h_addr = '0; h_wdata = '0;
    for (int i = 0; i < 40; i++) begin
      if (hold && mem_req) begin
        checks++;
        if (mem_addr !== h_addr || mem_we !== h_we || mem_wdata !== h_wdata) begin
          failures++;
          $display("FAIL %s_hold got addr=%h we=%b wdata=%h exp addr=%h we=%b wdata=%h",
                   nm, mem_addr, mem_we, mem_wdata, h_addr, h_we, h_wdata);
        end
      end
      hold = mem_req && !mem_ready;
      h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
      lat++;
      if (instr_done) begin
        got = 1;
        @(negedge clk); #1;
        break;
      end
      @(negedge clk); #1;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL %s_timeout got=no_instr_done exp=instr_done", nm);
    end
  endtask

  task automatic chk_lat_pc(input string nm, input int lat, input int elat, input logic [31:0] epc);
    // per-instruction latency and resulting pc
    checks++;
    if (lat !== elat) begin
      failures++; $display("FAIL %s_lat got=%0d exp=%0d", nm, lat, elat);
    end
    checks++;
    if (pc !== epc) begin
      failures++; $display("FAIL %s_pc got=%h exp=%h", nm, pc, epc);
    end
  endtask

  task automatic test_reset();
    begin_test(0);
    checks++;
    if (mem_req !== 1'b0 || instr_done !== 1'b0 || pc !== 32'h100 || instr !== 32'h0) begin
      failures++;
      $display("FAIL reset_hold got req=%b done=%b pc=%h ir=%h exp req=0 done=0 pc=100 ir=0",
               mem_req, instr_done, pc, instr);
    end
    release_rst();
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100 || pc !== 32'h100) begin
      failures++;
      $display("FAIL reset_first got req=%b we=%b addr=%h pc=%h exp req=1 we=0 addr=100 pc=100",
               mem_req, mem_we, mem_addr, pc);
    end
  endtask

  task automatic test_addi_add();
    int lat;
    begin_test(0);
    poke(32'h100, ei(8, 0, 5, 7));
    poke(32'h104, er(2, 5, 5, 6));
    poke(32'h108, ei(43, 0, 6, 32'h80));
    release_rst();
    run_instr("addi", lat); chk_lat_pc("addi", lat, 4, 32'h104);
    run_instr("add", lat);  chk_lat_pc("add", lat, 4, 32'h108);
    run_instr("sw6", lat);  chk_lat_pc("sw6", lat, 4, 32'h10C);
    checks++;
    if (mem[32'h80 >> 2] !== 32'd14) begin
      failures++; $display("FAIL add_result got=%h exp=%h", mem[32'h80 >> 2], 32'd14);
    end
  endtask

  task automatic test_store_load_wait();
    int lat;
    begin_test(0);
    poke(32'h300, 32'hDEADBEEF);
    poke(32'h100, ei(35, 0, 8, 32'h300));
    poke(32'h104, ei(43, 0, 8, 32'h40));
    poke(32'h108, ei(35, 0, 9, 32'h40));
    poke(32'h10C, ei(43, 0, 9, 32'h44));
    release_rst();
    run_instr("lw8", lat); chk_lat_pc("lw8", lat, 5, 32'h104);
    dwait = 2;
    run_instr("sw_wait", lat); chk_lat_pc("sw_wait", lat, 6, 32'h108);
    checks++;
    if (mem[32'h40 >> 2] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL sw_data got=%h exp=deadbeef", mem[32'h40 >> 2]);
    end
    run_instr("lw_wait", lat); chk_lat_pc("lw_wait", lat, 7, 32'h10C);
    run_instr("sw9", lat); chk_lat_pc("sw9", lat, 6, 32'h110);
    checks++;
    if (mem[32'h44 >> 2] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL lw_result got=%h exp=deadbeef", mem[32'h44 >> 2]);
    end
  endtask

  task automatic test_alu();
    logic [31:0] prog [0:16];
    logic [31:0] exp_v [0:7];
    int lat;
    prog = '{ei(8, 0, 1, -3), ei(8, 0, 2, 5), er(7, 1, 2, 3), er(6, 0, 2, 4),
             er(12, 1, 2, 10), er(0, 1, 2, 11), er(3, 0, 2, 12), ei(8, 0, 0, 9),
             er(2, 4, 2, 14), er(1, 2, 3, 15),
             ei(43, 0, 3, 32'h60), ei(43, 0, 4, 32'h64), ei(43, 0, 10, 32'h68),
             ei(43, 0, 11, 32'h6C), ei(43, 0, 12, 32'h70), ei(43, 0, 0, 32'h74),
             ei(43, 0, 14, 32'h78)};
    exp_v = '{32'h1, 32'hFFFFFFFB, 32'h2, 32'h5, 32'h0, 32'h0, 32'h0, SENT};
    begin_test(0);
    for (int i = 0; i < 17; i++) poke(32'h100 + 4 * i, prog[i]);
    poke(32'h144, ei(43, 0, 15, 32'h7C));
    release_rst();
    for (int i = 0; i < 18; i++) begin
      run_instr("alu", lat);
      chk_lat_pc("alu", lat, 4, 32'h104 + 32'(4 * i));
    end
    exp_v[7] = 32'h5;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem[(32'h60 >> 2) + i] !== exp_v[i]) begin
        failures++;
        $display("FAIL alu_word%0d got=%h exp=%h", i, mem[(32'h60 >> 2) + i], exp_v[i]);
      end
    end
  endtask

  task automatic test_branch();
    int lat;
    begin_test(0);
    poke(32'h100, ej(2, 32'h20));
    poke(32'h20, ei(4, 1, 0, -2));
    poke(32'h1C, ei(8, 0, 1, 1));
    release_rst();
    run_instr("j", lat);        chk_lat_pc("j", lat, 3, 32'h20);
    run_instr("beq_taken", lat); chk_lat_pc("beq_taken", lat, 3, 32'h1C);
    run_instr("addi1", lat);    chk_lat_pc("addi1", lat, 4, 32'h20);
    run_instr("beq_not", lat);  chk_lat_pc("beq_not", lat, 3, 32'h24);
  endtask

  task automatic test_jal_jr();
    int lat;
    begin_test(0);
    poke(32'h100, ej(2, 32'h30));
    poke(32'h30, ej(3, 32'h200));
    poke(32'h200, ei(43, 0, 127, 32'h48));
    poke(32'h204, ei(1, 127, 0, 0));
    release_rst();
    run_instr("j30", lat); chk_lat_pc("j30", lat, 3, 32'h30);
    run_instr("jal", lat); chk_lat_pc("jal", lat, 4, 32'h200);
    run_instr("sw127", lat); chk_lat_pc("sw127", lat, 4, 32'h204);
    checks++;
    if (mem[32'h48 >> 2] !== 32'h34) begin
      failures++; $display("FAIL jal_link got=%h exp=%h", mem[32'h48 >> 2], 32'h34);
    end
    run_instr("jr", lat); chk_lat_pc("jr", lat, 3, 32'h34);
  endtask

  task automatic test_reset_mid_store();
    int lat, nz;
    begin_test(3);
    poke(32'h100, ei(8, 0, 2, 5));
    poke(32'h104, ei(43, 0, 2, 32'h50));
    release_rst();
    run_instr("addi2", lat); chk_lat_pc("addi2", lat, 4, 32'h104);
    repeat (3) begin @(negedge clk); #1; end
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h50) begin
      failures++;
      $display("FAIL mid_mem got req=%b we=%b addr=%h exp req=1 we=1 addr=50", mem_req, mem_we, mem_addr);
    end
    reset = 1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || pc !== 32'h100 || instr_done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got req=%b we=%b pc=%h done=%b exp req=0 we=0 pc=100 done=0",
               mem_req, mem_we, pc, instr_done);
    end
    repeat (2) begin @(negedge clk); #1; end
    release_rst();
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin
      failures++;
      $display("FAIL mid_refetch got req=%b we=%b addr=%h exp req=1 we=0 addr=100", mem_req, mem_we, mem_addr);
    end
    checks++;
    if (mem[32'h50 >> 2] !== SENT) begin
      failures++; $display("FAIL mid_nowrite got=%h exp=%h", mem[32'h50 >> 2], SENT);
    end
    nz = 0;
    for (int i = 0; i < 128; i++) if (dut.rf_q[i] !== 32'h0) nz++;
    checks++;
    if (nz !== 0) begin
      failures++; $display("FAIL mid_regs_clear got nonzero=%0d exp=0", nz);
    end
  endtask

  initial begin
    test_reset();
    test_addi_add();
    test_store_load_wait();
    test_alu();
    test_branch();
    test_jal_jr();
    test_reset_mid_store();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
